// File: rtl/pipe_pkg.sv
// Shared opcodes, scoreboard stage encodings and the ALU for the parametrised
// ID/EX/WB forwarding core.
package pipe_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_LI  = 3'b111;

    localparam logic [1:0] SB_NONE = 2'b00;
    localparam logic [1:0] SB_WB   = 2'b01;
    localparam logic [1:0] SB_EX   = 2'b10;
    localparam logic [1:0] SB_BOTH = 2'b11;

    // The ALU works on zero-extended operands up to ALU_W bits; every op only
    // depends on low-order input bits, so a caller keeping the low XLEN result
    // bits gets exact modulo-2^XLEN arithmetic for any XLEN <= ALU_W.
    localparam int ALU_W = 64;

    function automatic logic [ALU_W-1:0] alu(input logic [2:0]       op,
                                             input logic [ALU_W-1:0] a,
                                             input logic [ALU_W-1:0] b);
        logic [ALU_W-1:0] res;
        res = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_MUL:  res = a * b;
            OP_LI:   res = b;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pipeline_param_if.sv
// Instruction-issue and write-back bundle of the pipeline core; the core side
// uses the slave modport, the instruction source uses master.
interface pipeline_param_if #(
    parameter int XLEN = 8,
    parameter int NREG = 4
);
    localparam int RIDX = $clog2(NREG);
    localparam int IW   = 3 + 3 * RIDX;

    logic [IW-1:0]   inst;
    logic            inst_valid;
    logic            inst_ready;
    logic            wb_valid;
    logic [RIDX-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;

    modport master (
        output inst, inst_valid,
        input  inst_ready, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  inst, inst_valid,
        output inst_ready, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// Per-register 2-bit pending-write tracker: bit 1 = write in EX, bit 0 = write
// in WB. Shifts one stage per normal cycle; a stall drains WB but holds EX.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG = 4,
    parameter int RIDX = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              alloc_en,
    input  logic [RIDX-1:0]   alloc_rd,
    input  logic [RIDX-1:0]   rs1_idx,
    input  logic [RIDX-1:0]   rs2_idx,
    output logic [2*NREG-1:0] sb_stage,
    output logic [1:0]        rs1_stage,
    output logic [1:0]        rs2_stage
);

    logic [1:0] r_sb [NREG];

    // NOTE: state registers use non-blocking assignments so every tracker
    // samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_sb[i] <= SB_NONE;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (stall) r_sb[i] <= {r_sb[i][1], 1'b0};
                else       r_sb[i] <= {alloc_en && (alloc_rd == RIDX'(i)), r_sb[i][1]};
            end
        end
    end

    // NOTE: combinational outputs get a full default first so no path can
    // leave them unassigned and infer a latch.
    always_comb begin
        sb_stage = '0;
        for (int i = 0; i < NREG; i++) sb_stage[2*i +: 2] = r_sb[i];
    end

    assign rs1_stage = r_sb[rs1_idx];
    assign rs2_stage = r_sb[rs2_idx];

endmodule

// File: rtl/pipeline_param.sv
// Parametrised 3-stage (ID/EX/WB) forwarding core with valid/ready issue,
// a 2-cycle MUL that stalls issue, and exported scoreboard/retire state.
module pipeline_param
    import pipe_pkg::*;
#(
    parameter int  XLEN = 8,
    parameter int  NREG = 4,
    localparam int RIDX = $clog2(NREG),
    localparam int IW   = 3 + 3 * RIDX
) (
    input  logic                clk,
    input  logic                rst,
    pipeline_param_if.slave     bus,
    input  logic [RIDX-1:0]     dbg_rd_idx,
    output logic [XLEN-1:0]     dbg_rd_data,
    output logic [2*NREG-1:0]   sb_stage,
    output logic                id_ex_wen,
    output logic                ex_wb_wen,
    output logic [RIDX-1:0]     id_ex_rd,
    output logic [RIDX-1:0]     ex_wb_rd
);

    logic [2:0]      w_op;
    logic [RIDX-1:0] w_rs1, w_rs2, w_rd;
    logic [1:0]      w_rs1_stage, w_rs2_stage;
    logic [XLEN-1:0] w_op_a, w_op_b, w_ex_result;
    logic            w_stall, w_accept, w_alloc_en;

    logic            r_id_ex_wen;
    logic [2:0]      r_id_ex_op;
    logic [RIDX-1:0] r_id_ex_rd;
    logic [XLEN-1:0] r_id_ex_a, r_id_ex_b;
    logic            r_mul_second;
    logic            r_ex_wb_wen;
    logic [RIDX-1:0] r_ex_wb_rd;
    logic [XLEN-1:0] r_ex_wb_data;
    logic [XLEN-1:0] r_regs [NREG];

    assign {w_op, w_rs1, w_rs2, w_rd} = bus.inst;

    // First EX cycle of a MUL: hold ID/EX, refuse issue, bubble into EX/WB.
    assign w_stall    = r_id_ex_wen && (r_id_ex_op == OP_MUL) && !r_mul_second;
    assign w_accept   = bus.inst_valid && !w_stall;
    assign w_alloc_en = w_accept && (w_op != OP_NOP);

    assign w_ex_result = XLEN'(alu(r_id_ex_op, ALU_W'(r_id_ex_a), ALU_W'(r_id_ex_b)));

    pipe_scoreboard #(
        .NREG (NREG),
        .RIDX (RIDX)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .stall     (w_stall),
        .alloc_en  (w_alloc_en),
        .alloc_rd  (w_rd),
        .rs1_idx   (w_rs1),
        .rs2_idx   (w_rs2),
        .sb_stage  (sb_stage),
        .rs1_stage (w_rs1_stage),
        .rs2_stage (w_rs2_stage)
    );

    // Youngest producer wins: EX result over EX/WB value over register file.
    always_comb begin
        w_op_a = r_regs[w_rs1];
        w_op_b = r_regs[w_rs2];
        unique case (w_rs1_stage)
            SB_NONE:        w_op_a = r_regs[w_rs1];
            SB_WB:          w_op_a = r_ex_wb_data;
            SB_EX, SB_BOTH: w_op_a = w_ex_result;
        endcase
        unique case (w_rs2_stage)
            SB_NONE:        w_op_b = r_regs[w_rs2];
            SB_WB:          w_op_b = r_ex_wb_data;
            SB_EX, SB_BOTH: w_op_b = w_ex_result;
        endcase
        if (w_op == OP_LI) w_op_b = XLEN'({w_rs1, w_rs2});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_id_ex_wen  <= 1'b0;
            r_id_ex_op   <= OP_NOP;
            r_id_ex_rd   <= '0;
            r_id_ex_a    <= '0;
            r_id_ex_b    <= '0;
            r_mul_second <= 1'b0;
            r_ex_wb_wen  <= 1'b0;
            r_ex_wb_rd   <= '0;
            r_ex_wb_data <= '0;
        end else begin
            r_mul_second <= w_stall;
            if (!w_stall) begin
                r_id_ex_wen <= w_alloc_en;
                r_id_ex_op  <= w_op;
                r_id_ex_rd  <= w_rd;
                r_id_ex_a   <= w_op_a;
                r_id_ex_b   <= w_op_b;
            end
            r_ex_wb_wen  <= r_id_ex_wen && !w_stall;
            r_ex_wb_rd   <= r_id_ex_rd;
            r_ex_wb_data <= w_ex_result;
        end
    end

    // NOTE: the register file is reset on purpose: architectural registers
    // must read zero after reset, which outweighs the usual no-reset RAM style.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (r_ex_wb_wen) begin
            r_regs[r_ex_wb_rd] <= r_ex_wb_data;
        end
    end

    assign bus.inst_ready = !w_stall;
    assign bus.wb_valid   = r_ex_wb_wen;
    assign bus.wb_rd      = r_ex_wb_rd;
    assign bus.wb_data    = r_ex_wb_data;

    assign dbg_rd_data = r_regs[dbg_rd_idx];
    assign id_ex_wen   = r_id_ex_wen;
    assign ex_wb_wen   = r_ex_wb_wen;
    assign id_ex_rd    = r_id_ex_rd;
    assign ex_wb_rd    = r_ex_wb_rd;

endmodule

// File: tb/tb_pipeline_param.sv
// Directed self-checking bench for pipeline_param (XLEN=8, NREG=4): forwarding,
// MUL stall, wrap-around, bubbles, logic ops, NOP and reset in the middle of a MUL.
module tb_pipeline_param;
    import pipe_pkg::*;

    localparam int XLEN = 8;
    localparam int NREG = 4;
    localparam int RIDX = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [RIDX-1:0]     dbg_rd_idx;
    logic [XLEN-1:0]     dbg_rd_data;
    logic [2*NREG-1:0]   sb_stage;
    logic                id_ex_wen, ex_wb_wen;
    logic [RIDX-1:0]     id_ex_rd, ex_wb_rd;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_param_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

    pipeline_param #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_rd_idx  (dbg_rd_idx),
        .dbg_rd_data (dbg_rd_data),
        .sb_stage    (sb_stage),
        .id_ex_wen   (id_ex_wen),
        .ex_wb_wen   (ex_wb_wen),
        .id_ex_rd    (id_ex_rd),
        .ex_wb_rd    (ex_wb_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [8:0] mk(input logic [2:0] op, input int rs1, input int rs2, input int rd);
        return {op, 2'(rs1), 2'(rs2), 2'(rd)};
    endfunction

    function automatic logic [8:0] li(input int rd, input int imm);
        return mk(OP_LI, imm >> 2, imm & 3, rd);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input int rd, input int data);
        check({tag, "_valid"}, bus.wb_valid, 1);
        check({tag, "_rd"}, bus.wb_rd, rd);
        check({tag, "_data"}, bus.wb_data, data);
    endtask

    task automatic check_reg(input string tag, input int idx, input int data);
        dbg_rd_idx = 2'(idx);
        #1;
        check(tag, dbg_rd_data, data);
    endtask

    logic [8:0] alu_insts [5];
    int         alu_rd    [5];
    int         alu_data  [5];

    initial begin
        bus.inst_valid = 1'b0;
        bus.inst       = '0;
        dbg_rd_idx     = '0;

        // Reset held for two edges
        tick();
        tick();
        rst = 1'b1;
        check("rst_ready", bus.inst_ready, 1);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_sb", sb_stage, 0);
        check("rst_id_ex_wen", id_ex_wen, 0);
        check("rst_ex_wb_wen", ex_wb_wen, 0);
        for (int i = 0; i < NREG; i++) check_reg($sformatf("rst_reg%0d", i), i, 0);

        // Back-to-back forwarding: LI r1,5; LI r2,3; ADD r3=r1+r2
        bus.inst_valid = 1'b1;
        bus.inst = li(1, 5);
        tick();
        check("fwd_sb_li1", sb_stage, 8'h08);
        bus.inst = li(2, 3);
        tick();
        check_wb("fwd_wb_li1", 1, 5);
        check("fwd_sb_add_issue", sb_stage, 8'h24);
        bus.inst = mk(OP_ADD, 1, 2, 3);
        tick();
        check_wb("fwd_wb_li2", 2, 3);
        check("fwd_sb_add_ex", sb_stage, 8'h90);
        bus.inst_valid = 1'b0;
        tick();
        check_wb("fwd_wb_add", 3, 8);
        tick();
        check("fwd_idle_wb", bus.wb_valid, 0);
        check_reg("fwd_r1", 1, 5);
        check_reg("fwd_r2", 2, 3);
        check_reg("fwd_r3", 3, 8);

        // MUL stall: MUL r0=r1*r2 then SUB r1=r0-r2
        check("mul_ready_before", bus.inst_ready, 1);
        bus.inst_valid = 1'b1;
        bus.inst = mk(OP_MUL, 1, 2, 0);
        tick();
        check("mul_ready_stall", bus.inst_ready, 0);
        check("mul_sb0_c1", sb_stage[1:0], 2'b10);
        check("mul_wb_bubble1", bus.wb_valid, 0);
        bus.inst = mk(OP_SUB, 0, 2, 1);
        tick();
        check("mul_ready_second", bus.inst_ready, 1);
        check("mul_sb0_c2", sb_stage[1:0], 2'b10);
        check("mul_wb_bubble2", bus.wb_valid, 0);
        tick();
        bus.inst_valid = 1'b0;
        check_wb("mul_wb_r0", 0, 15);
        check("mul_sb0_c3", sb_stage[1:0], 2'b01);
        check("mul_ready_after", bus.inst_ready, 1);
        tick();
        check_wb("mul_wb_sub", 1, 12);
        check("mul_sb0_c4", sb_stage[1:0], 2'b00);
        check("mul_sb_full", sb_stage, 8'h04);
        tick();
        check("mul_idle_wb", bus.wb_valid, 0);
        check_reg("mul_r0", 0, 15);
        check_reg("mul_r1", 1, 12);

        // Wrap-around: LI r1,15; MUL r2=r1*r1; ADD r3=r2+r2
        bus.inst_valid = 1'b1;
        bus.inst = li(1, 15);
        tick();
        bus.inst = mk(OP_MUL, 1, 1, 2);
        tick();
        check("wrap_ready_stall", bus.inst_ready, 0);
        check_wb("wrap_wb_li", 1, 15);
        bus.inst = mk(OP_ADD, 2, 2, 3);
        tick();
        check("wrap_ready_second", bus.inst_ready, 1);
        check("wrap_wb_bubble", bus.wb_valid, 0);
        tick();
        bus.inst_valid = 1'b0;
        check_wb("wrap_wb_mul", 2, 225);
        tick();
        check_wb("wrap_wb_add", 3, 194);
        tick();
        check("wrap_idle_wb", bus.wb_valid, 0);

        // Bubbles after LI r2,9
        bus.inst_valid = 1'b1;
        bus.inst = li(2, 9);
        tick();
        bus.inst_valid = 1'b0;
        check("bub_sb2_c1", sb_stage[5:4], 2'b10);
        tick();
        check("bub_sb2_c2", sb_stage[5:4], 2'b01);
        check_wb("bub_wb", 2, 9);
        tick();
        check("bub_sb2_c3", sb_stage[5:4], 2'b00);
        check("bub_wb_none1", bus.wb_valid, 0);
        check_reg("bub_r2", 2, 9);
        tick();
        check("bub_wb_none2", bus.wb_valid, 0);

        // Logic ops, consecutive issue with mixed forwarding paths
        alu_insts[0] = li(1, 12);            alu_rd[0] = 1; alu_data[0] = 12;
        alu_insts[1] = li(2, 10);            alu_rd[1] = 2; alu_data[1] = 10;
        alu_insts[2] = mk(OP_AND, 1, 2, 0);  alu_rd[2] = 0; alu_data[2] = 8;
        alu_insts[3] = mk(OP_OR,  1, 2, 3);  alu_rd[3] = 3; alu_data[3] = 14;
        alu_insts[4] = mk(OP_XOR, 1, 2, 0);  alu_rd[4] = 0; alu_data[4] = 6;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                bus.inst_valid = 1'b1;
                bus.inst = alu_insts[k];
            end else begin
                bus.inst_valid = 1'b0;
            end
            tick();
            if (k >= 1) check_wb($sformatf("alu_wb%0d", k - 1), alu_rd[k-1], alu_data[k-1]);
        end
        bus.inst_valid = 1'b0;
        tick();
        check_reg("alu_r0", 0, 6);
        check_reg("alu_r3", 3, 14);

        // NOP writes nothing
        bus.inst_valid = 1'b1;
        bus.inst = mk(OP_NOP, 1, 1, 2);
        tick();
        bus.inst_valid = 1'b0;
        check("nop_id_ex_wen", id_ex_wen, 0);
        check("nop_sb", sb_stage, 0);
        tick();
        check("nop_wb1", bus.wb_valid, 0);
        tick();
        check("nop_wb2", bus.wb_valid, 0);
        check_reg("nop_r2", 2, 10);

        // Reset in the first MUL EX cycle discards the MUL
        bus.inst_valid = 1'b1;
        bus.inst = mk(OP_MUL, 1, 1, 0);
        tick();
        check("rmul_ready_stall", bus.inst_ready, 0);
        rst = 1'b0;
        bus.inst_valid = 1'b0;
        tick();
        rst = 1'b1;
        check("rmul_wb_rst", bus.wb_valid, 0);
        check("rmul_sb_rst", sb_stage, 0);
        check("rmul_ready_rst", bus.inst_ready, 1);
        tick();
        check("rmul_wb_after", bus.wb_valid, 0);
        check("rmul_ready_after", bus.inst_ready, 1);
        check("rmul_sb_after", sb_stage, 0);
        check_reg("rmul_r0", 0, 0);
        tick();
        check("rmul_wb_late", bus.wb_valid, 0);
        check_reg("rmul_r0_late", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
